wb_retire_stage: RTL
====================

# wb_retire_stage

Parametrised writeback/retire stage for the five-stage in-order pipeline, placed after the memory-access stage. Holds one instruction behind a valid/allowin handshake, writes the register file with byte strobes on the retire cycle, counts retired instructions, and emits a debug trace stream. The trace stream has valid/ready backpressure and an optional buffer, so a slow trace consumer stalls the pipeline instead of losing trace entries.

## Interface
- `DATA_W`, 32, register data width; multiple of 8.
- `AW`, 5, register address width.
- `PC_W`, 32, PC width.
- `TRACE_DEPTH`, 4, trace buffer entries; power of two, ≥2.
- `CNT_W`, 32, retire-counter width.
- Derived: `BE_W = DATA_W/8`; `IN_W = BE_W+AW+DATA_W+PC_W`; `RF_W = BE_W+AW+DATA_W`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `ma_validout` in 1: upstream has a valid instruction.
- `ma_to_wb_bus` in IN_W: {wstrb[BE_W], dest[AW], result[DATA_W], pc[PC_W]}, MSB first.
- `wb_allowin` out 1: stage accepts a new instruction this cycle.
- `flush` in 1: cancel the instruction held in the stage.
- `wb_regfile_bus` out RF_W: {rf_we[BE_W], rf_waddr[AW], rf_wdata[DATA_W]}.
- `wb_valid` out 1: stage holds a valid instruction (for hazard logic).
- `wb_dest` out AW: dest of the held instruction; 0 when it is invalid or wstrb==0.
- `trace_valid` out 1 / `trace_ready` in 1: trace handshake.
- `trace_pc` out PC_W, `trace_we` out BE_W, `trace_wnum` out AW, `trace_wdata` out DATA_W: trace payload.
- `retire_cnt` out CNT_W: count of retired instructions.

## Operation
- Stage register: `valid` and `bus_r`.
  - `bus_r` loads `ma_to_wb_bus` when `ma_validout & wb_allowin`.
  - `valid` loads `ma_validout` when `wb_allowin`.
- `retire = valid & readygo & ~flush`.
- `wb_allowin = ~valid | readygo | flush`.
- Flush: `valid` clears on the next edge.
  - If `ma_validout` arrives in the same cycle, flush wins: `valid` becomes 0 and the new instruction is discarded.
  - Flush never touches trace entries that are already buffered.
- Register file write: `rf_we = retire ? wstrb : 0`. Writes occur exactly once, on the retire cycle. `rf_waddr = dest`. `rf_wdata = result`.
- `retire_cnt` increments by 1 on each retire and wraps at 2^CNT_W.
- Every retire produces exactly one trace entry {pc, `rf_we`, dest, result}. This includes entries with `rf_we` = 0.
- A trace handshake occurs when `trace_valid & trace_ready`.
- All trace payload outputs read 0 whenever `trace_valid` = 0.

## Timing
- Reset values:
  - `valid`, `bus_r`, trace buffer pointers, buffer count and `retire_cnt` are all 0.
  - `wb_allowin` = 1; `wb_regfile_bus` = 0; `wb_valid` = 0; `wb_dest` = 0; `trace_valid` = 0; all trace payload outputs = 0.
- Reset asserted mid-operation drops the held instruction and all buffered trace entries immediately; no write occurs.
- An instruction accepted at edge N can retire in cycle N+1 at the earliest, so stage latency is 1 cycle.
- Back-to-back instructions are sustained at 1 per cycle while `readygo` = 1.
- `wb_allowin` combinationally depends on `flush`, and on `trace_ready` when the trace buffer is compiled out.

## Configuration
- `WB_TRACE_FIFO_EN` defined: a `TRACE_DEPTH`-entry circular buffer sits on the trace path.
  - `readygo = (count != TRACE_DEPTH)`; this is a registered signal with no combinational path from `trace_ready`.
  - A retire pushes an entry; a handshake pops the head.
  - Push and pop in the same cycle leave `count` unchanged; this is legal when full only if a pop occurs, and no push happens while full.
  - Read and write pointers wrap modulo `TRACE_DEPTH`.
  - `trace_valid = (count != 0)`. An entry pushed into an empty buffer becomes visible in the cycle after the push.
- `WB_TRACE_FIFO_EN` undefined: no buffer.
  - `trace_valid = valid & ~flush`; payload comes directly from `bus_r`, with `trace_we = wstrb`.
  - `readygo = trace_ready`; trace latency is 0.

## Test plan
- Reset release, `trace_ready` = 1: drive pc=0x1C000000, dest=5, result=0xDEADBEEF, wstrb=0xF.
  - Next cycle: `wb_regfile_bus` = {0xF, 5, 0xDEADBEEF} for exactly one cycle; `retire_cnt` = 1.
  - Trace entry matches (one cycle later when the buffer is compiled in).
- Streaming with `trace_ready` = 1: 8 consecutive instructions → 8 retires in 8 cycles; `wb_allowin` stays 1; `retire_cnt` = 8.
- Backpressure with buffer, `trace_ready` = 0: 4 retires fill the buffer.
  - The 5th instruction holds: `wb_allowin` = 0, no register write.
  - Raise `trace_ready`: entries drain in order; the 5th instruction then retires.
- Flush: hold an instruction with wstrb=0xF via backpressure, assert `flush` together with `ma_validout`.
  - No register write, no trace entry; `valid` = 0 next cycle; `retire_cnt` unchanged.
- wstrb=0x3, dest=0 → `rf_we` = 0x3 and `trace_we` = 0x3; `wb_dest` = 0.
- Counter wrap (CNT_W=4): 17 retires → `retire_cnt` = 1. Asynchronous reset pulse mid-stall → all outputs return to reset values.

Source files
------------

// File: rtl/wb_retire_stage.sv
// wb_retire_stage: writeback/retire stage with register-file write, retire counter and trace stream.
// Optional trace buffer is enabled by defining WB_TRACE_FIFO_EN; by default the trace is unbuffered.
module wb_retire_stage #(
    parameter int DATA_W      = 32,
    parameter int AW          = 5,
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 4,
    parameter int CNT_W       = 32,
    localparam int BE_W       = DATA_W / 8,
    localparam int IN_W       = BE_W + AW + DATA_W + PC_W,
    localparam int RF_W       = BE_W + AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ma_validout,
    input  logic [IN_W-1:0]   ma_to_wb_bus,
    output logic              wb_allowin,
    input  logic              flush,
    output logic [RF_W-1:0]   wb_regfile_bus,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_dest,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [PC_W-1:0]   trace_pc,
    output logic [BE_W-1:0]   trace_we,
    output logic [AW-1:0]     trace_wnum,
    output logic [DATA_W-1:0] trace_wdata,
    output logic [CNT_W-1:0]  retire_cnt
);

    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 || DATA_W % 8 != 0) begin : g_param_err
        $error("wb_retire_stage: TRACE_DEPTH must be a power of two >= 2 and DATA_W a multiple of 8");
    end

    logic              valid_q, valid_d;
    logic [IN_W-1:0]   bus_q, bus_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              readygo;
    logic              retire;
    logic [BE_W-1:0]   wstrb;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   pc;

    assign {wstrb, dest, result, pc} = bus_q;
    assign wb_allowin     = ~valid_q | readygo | flush;
    assign retire         = valid_q & readygo & ~flush;
    assign wb_regfile_bus = {retire ? wstrb : {BE_W{1'b0}}, dest, result};
    assign wb_valid       = valid_q;
    assign wb_dest        = (valid_q & |wstrb) ? dest : {AW{1'b0}};
    assign retire_cnt     = cnt_q;

    // Stage register next state: flush kills both the held and any incoming instruction
    always_comb begin
        valid_d = wb_allowin ? (ma_validout & ~flush) : valid_q;
        bus_d   = (ma_validout & wb_allowin) ? ma_to_wb_bus : bus_q;
        cnt_d   = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Stage register and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            bus_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            bus_q   <= bus_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_TRACE_FIFO_EN
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = PC_W + BE_W + AW + DATA_W;

    logic [TW-1:0] mem_q [TRACE_DEPTH];
    logic [TW-1:0] mem_d [TRACE_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] tc_q, tc_d;
    logic          pop;

    // readygo comes only from the registered fill level, so trace_ready never reaches wb_allowin
    assign readygo     = tc_q != CW'(TRACE_DEPTH);
    assign trace_valid = tc_q != '0;
    assign pop         = trace_valid & trace_ready;
    assign {trace_pc, trace_we, trace_wnum, trace_wdata} = trace_valid ? mem_q[rp_q] : {TW{1'b0}};

    // Circular buffer: each retire pushes its entry, each handshake pops the head
    always_comb begin
        mem_d = mem_q;
        if (retire) mem_d[wp_q] = {pc, wstrb, dest, result};
        wp_d = wp_q + PW'(retire);
        rp_d = rp_q + PW'(pop);
        tc_d = tc_q + CW'(retire) - CW'(pop);
    end

    // Trace buffer storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++) mem_q[i] <= '0;
            wp_q <= '0;
            rp_q <= '0;
            tc_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            tc_q  <= tc_d;
        end
    end
`else
    assign readygo     = trace_ready;
    assign trace_valid = valid_q & ~flush;
    assign {trace_pc, trace_we, trace_wnum, trace_wdata} =
        trace_valid ? {pc, wstrb, dest, result} : {(PC_W + BE_W + AW + DATA_W){1'b0}};
`endif

endmodule
